// File: rtl/alu_pkg.sv
// Shared constants for the execute stage: datapath width and ALU opcode encoding.
// Optional multiplier is enabled by defining ALU_MULT_EN.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_MULT  = 4'd11;
  localparam logic [3:0] ALU_MULTU = 4'd12;
  localparam logic [3:0] ALU_ADDU  = 4'd13;
  localparam logic [3:0] ALU_SUBU  = 4'd14;
  localparam logic [3:0] ALU_LUI   = 4'd15;

  // Signed overflow from operand and result sign bits; b_sign is already inverted for SUB.
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                      input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/alu_branch_exec_if.sv
// Execute-stage bus: ALU/branch inputs from control/regfile and registered results back.
interface alu_branch_exec_if;
  import alu_pkg::*;

  logic             en;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] read_data1;
  logic [4:0]       shamt;
  logic             select_shamt;
  logic [WIDTH-1:0] alu_srcB;
  logic             branch_en;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] pc;

  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             overflow;
  logic             alu_zero;
  logic [WIDTH-1:0] pc_out;

  modport master (
    output en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
           branch_en, imm, pc,
    input  alu_result, hi, lo, overflow, alu_zero, pc_out
  );

  modport slave (
    input  en, alu_control, read_data1, shamt, select_shamt, alu_srcB,
           branch_en, imm, pc,
    output alu_result, hi, lo, overflow, alu_zero, pc_out
  );

endinterface

// File: rtl/alu_src_sel.sv
// Combinational operand-A mux: rs data or zero-extended instruction shift amount.
module alu_src_sel
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] read_data1_i,
  input  logic [4:0]       shamt_i,
  input  logic             select_shamt_i,
  output logic [WIDTH-1:0] operand_a_o
);

  logic [WIDTH-1:0] shamt_ext;
  assign shamt_ext = {{(WIDTH-5){1'b0}}, shamt_i};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    assign operand_a_o[gi] = select_shamt_i ? shamt_ext[gi] : read_data1_i[gi];
  end

endmodule

// File: rtl/alu_branch_exec.sv
// Execute stage: registered 32-bit ALU with HI/LO products and zero-flag branch target.
// Define ALU_MULT_EN to build the multiplier for opcodes 11/12.
module alu_branch_exec
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  alu_branch_exec_if.slave  bus
);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       sh_amt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  logic [WIDTH-1:0] result_d, result_q;
  logic             ovf_d, ovf_q;
  logic             zero_q;
  logic [WIDTH-1:0] pc_q;

  alu_src_sel u_src_sel (
    .read_data1_i   (bus.read_data1),
    .shamt_i        (bus.shamt),
    .select_shamt_i (bus.select_shamt),
    .operand_a_o    (op_a)
  );

  assign op_b   = bus.alu_srcB;
  assign sh_amt = op_a[4:0];
  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;

`ifdef ALU_MULT_EN
  logic [WIDTH-1:0]   hi_d, hi_q;
  logic [WIDTH-1:0]   lo_d, lo_q;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  assign prod_s = $unsigned($signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) *
                            $signed({{WIDTH{op_b[WIDTH-1]}}, op_b}));
  assign prod_u = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
`endif

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
`ifdef ALU_MULT_EN
    hi_d     = hi_q;
    lo_d     = lo_q;
`endif
    case (bus.alu_control)
      ALU_ADD: begin
        result_d = sum;
        ovf_d    = signed_ovf(op_a[WIDTH-1], op_b[WIDTH-1], sum[WIDTH-1]);
      end
      ALU_SUB: begin
        result_d = diff;
        ovf_d    = signed_ovf(op_a[WIDTH-1], ~op_b[WIDTH-1], diff[WIDTH-1]);
      end
      ALU_AND:  result_d = op_a & op_b;
      ALU_OR:   result_d = op_a | op_b;
      ALU_XOR:  result_d = op_a ^ op_b;
      ALU_NOR:  result_d = ~(op_a | op_b);
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  result_d = op_b << sh_amt;
      ALU_SRL:  result_d = op_b >> sh_amt;
      ALU_SRA:  result_d = $unsigned($signed(op_b) >>> sh_amt);
`ifdef ALU_MULT_EN
      ALU_MULT: begin
        result_d = prod_s[WIDTH-1:0];
        hi_d     = prod_s[2*WIDTH-1:WIDTH];
        lo_d     = prod_s[WIDTH-1:0];
      end
      ALU_MULTU: begin
        result_d = prod_u[WIDTH-1:0];
        hi_d     = prod_u[2*WIDTH-1:WIDTH];
        lo_d     = prod_u[WIDTH-1:0];
      end
`else
      // Without the multiplier these opcodes retire a zero result.
      ALU_MULT:  result_d = '0;
      ALU_MULTU: result_d = '0;
`endif
      ALU_ADDU: result_d = sum;
      ALU_SUBU: result_d = diff;
      ALU_LUI:  result_d = op_b << 16;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      pc_q     <= '0;
`ifdef ALU_MULT_EN
      hi_q     <= '0;
      lo_q     <= '0;
`endif
    end else begin
      if (bus.en) begin
        result_q <= result_d;
        ovf_q    <= ovf_d;
        zero_q   <= (result_d == '0);
`ifdef ALU_MULT_EN
        hi_q     <= hi_d;
        lo_q     <= lo_d;
`endif
      end
      // Branch decision uses the zero flag registered before this edge.
      if (bus.branch_en) begin
        pc_q <= zero_q ? (bus.pc + bus.imm) : bus.pc;
      end
    end
  end

  assign bus.alu_result = result_q;
  assign bus.overflow   = ovf_q;
  assign bus.alu_zero   = zero_q;
  assign bus.pc_out     = pc_q;
`ifdef ALU_MULT_EN
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
`else
  assign bus.hi         = '0;
  assign bus.lo         = '0;
`endif

endmodule

// File: tb/tb_alu_branch_exec.sv
// Scoreboard bench for alu_branch_exec: driver pushes model predictions, monitor pops and compares.
module tb_alu_branch_exec;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  alu_branch_exec_if bus ();

  alu_branch_exec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] pc;
    logic        ovf;
    logic        zero;
    int          op;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int txn = 0;

  // Reference state: the architectural values the outputs should hold.
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0, m_pc = '0;
  logic        m_ovf = 1'b0, m_zero = 1'b0;

  localparam longint INT_MAX = 64'sd2147483647;
  localparam longint INT_MIN = -64'sd2147483648;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d: got %h expected %h", name, txn, act, req);
    end
  endtask

  // Behavioural ALU from the instruction-set definition.
  task automatic alu_ref(input int op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf,
                         output bit hl_wr, output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint wide;
    longint unsigned uwide;
    sa = a; sb = b;
    res = '0; ovf = 1'b0; hl_wr = 1'b0; hi = '0; lo = '0;
    case (op)
      0: begin wide = longint'(sa) + longint'(sb); res = wide[31:0];
               ovf = (wide > INT_MAX) || (wide < INT_MIN); end
      1: begin wide = longint'(sa) - longint'(sb); res = wide[31:0];
               ovf = (wide > INT_MAX) || (wide < INT_MIN); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = ~(a | b);
      6: res = (sa < sb) ? 32'd1 : 32'd0;
      7: res = (a < b) ? 32'd1 : 32'd0;
      8: res = b << a[4:0];
      9: res = b >> a[4:0];
      10: res = sb >>> a[4:0];
      11: begin
`ifdef ALU_MULT_EN
        wide = longint'(sa) * longint'(sb);
        hi = wide[63:32]; lo = wide[31:0]; res = lo; hl_wr = 1'b1;
`endif
      end
      12: begin
`ifdef ALU_MULT_EN
        uwide = 64'(a) * 64'(b);
        hi = uwide[63:32]; lo = uwide[31:0]; res = lo; hl_wr = 1'b1;
`endif
      end
      13: res = a + b;
      14: res = a - b;
      default: res = b << 16;
    endcase
  endtask

  task automatic drive(input bit rst, input bit e, input int op, input logic [31:0] rd1,
                       input logic [4:0] sh, input bit sel, input logic [31:0] b,
                       input bit br, input logic [31:0] im, input logic [31:0] p);
    logic [31:0] a, r, h, l;
    logic o;
    bit hw;
    exp_t x;
    @(negedge clk);
    reset = rst;
    bus.en = e; bus.alu_control = 4'(op); bus.read_data1 = rd1; bus.shamt = sh;
    bus.select_shamt = sel; bus.alu_srcB = b; bus.branch_en = br; bus.imm = im; bus.pc = p;
    if (rst) begin
      m_res = '0; m_hi = '0; m_lo = '0; m_pc = '0; m_ovf = 1'b0; m_zero = 1'b0;
    end else begin
      if (br) m_pc = m_zero ? p + im : p;
      if (e) begin
        a = sel ? {27'd0, sh} : rd1;
        alu_ref(op, a, b, r, o, hw, h, l);
        m_res = r; m_ovf = o; m_zero = (r == 32'd0);
        if (hw) begin m_hi = h; m_lo = l; end
      end
    end
    x.res = m_res; x.hi = m_hi; x.lo = m_lo; x.pc = m_pc;
    x.ovf = m_ovf; x.zero = m_zero; x.op = op;
    exp_q.push_back(x);
  endtask

  // Monitor: every edge that follows a driven cycle has one prediction waiting.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("alu_result", bus.alu_result, x.res);
        chk("hi", bus.hi, x.hi);
        chk("lo", bus.lo, x.lo);
        chk("pc_out", bus.pc_out, x.pc);
        chk("overflow", {31'd0, bus.overflow}, {31'd0, x.ovf});
        chk("alu_zero", {31'd0, bus.alu_zero}, {31'd0, x.zero});
        $display("txn %0d op=%0d res=%h hi=%h lo=%h ovf=%b zero=%b pc=%h",
                 txn, x.op, bus.alu_result, bus.hi, bus.lo, bus.overflow,
                 bus.alu_zero, bus.pc_out);
        txn++;
      end
    end
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    bus.en = 1'b0; bus.alu_control = '0; bus.read_data1 = '0; bus.shamt = '0;
    bus.select_shamt = 1'b0; bus.alu_srcB = '0; bus.branch_en = 1'b0;
    bus.imm = '0; bus.pc = '0;

    // Reset with en/branch_en asserted, then idle.
    drive(1, 1, 0, 32'h1234, 5'd3, 0, 32'h5, 1, 32'h8, 32'h40);
    drive(1, 1, 3, 32'hFF, 5'd1, 0, 32'h1, 1, 32'h8, 32'h44);
    drive(0, 0, 0, 32'h1, 5'd0, 0, 32'h1, 0, 32'h0, 32'h50);
    drive(0, 0, 5, 32'h0, 5'd0, 0, 32'h0, 0, 32'h4, 32'h54);
    // Overflow boundary.
    drive(0, 1, 0,  32'h7FFF_FFFF, 5'd0, 0, 32'h1, 0, 32'h0, 32'h0);
    drive(0, 1, 13, 32'h7FFF_FFFF, 5'd0, 0, 32'h1, 0, 32'h0, 32'h0);
    // Shifts using the shamt source.
    drive(0, 1, 8,  32'hFFFF, 5'd4, 1, 32'h1, 0, 32'h0, 32'h0);
    drive(0, 1, 10, 32'hFFFF, 5'd4, 1, 32'h8000_0000, 0, 32'h0, 32'h0);
    drive(0, 1, 9,  32'hFFFF, 5'd0, 1, 32'h8000_0001, 0, 32'h0, 32'h0);
    // Branch taken, then not taken.
    drive(0, 1, 1, 32'd5, 5'd0, 0, 32'd5, 0, 32'h0, 32'h0);
    drive(0, 0, 1, 32'd5, 5'd0, 0, 32'd5, 1, 32'hFFFF_FFFE, 32'h10);
    drive(0, 1, 1, 32'd5, 5'd0, 0, 32'd3, 0, 32'h0, 32'h0);
    drive(0, 0, 1, 32'd5, 5'd0, 0, 32'd3, 1, 32'hFFFF_FFFE, 32'h10);
    // Multiply and HI/LO hold.
    drive(0, 1, 11, 32'hFFFF_FFFF, 5'd0, 0, 32'd2, 0, 32'h0, 32'h0);
    drive(0, 1, 12, 32'hFFFF_FFFF, 5'd0, 0, 32'd2, 0, 32'h0, 32'h0);
    drive(0, 1, 3,  32'h0F0F_0000, 5'd0, 0, 32'h0000_00F0, 0, 32'h0, 32'h0);
    // SLT then hold with changing inputs.
    drive(0, 1, 6, 32'hFFFF_FFFF, 5'd0, 0, 32'd1, 0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++)
      drive(0, 0, int'($urandom_range(0, 15)), $urandom, 5'($urandom), 1'($urandom),
            $urandom, 0, $urandom, $urandom);
    // Simultaneous en and branch_en: branch sees the pre-edge zero flag.
    drive(0, 1, 14, 32'd7, 5'd0, 0, 32'd7, 1, 32'd8, 32'h100);
    drive(0, 1, 14, 32'd7, 5'd0, 0, 32'd6, 1, 32'd8, 32'h200);
    drive(0, 1, 15, 32'd0, 5'd0, 0, 32'h0000_ABCD, 1, 32'd8, 32'h300);

    for (int i = 0; i < 400; i++) begin
      v = pick_val();
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 15)), v, 5'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0) ? v : pick_val(),
            1'($urandom), pick_val(), $urandom);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_branch_exec.md
Name: alu_branch_exec

Overview:
- Execute-stage datapath block for the multicycle MIPS core. It contains three parts:
  - an operand-A source select (rs data or shift amount);
  - a 32-bit ALU with HI/LO multiply results;
  - a branch target unit that computes the next PC from the ALU zero flag.
- All results are registered so the control FSM can sample them in the state after EXECUTE and BRANCH.

Parameters:
- WIDTH, 32, datapath width (fixed; MIPS word).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  ALU enable; when 1 at an edge, ALU outputs update.
- alu_control  in  4  operation select (encoding below).
- read_data1  in  32  rs register value.
- shamt  in  5  instruction shift amount.
- select_shamt  in  1  1: operand A = zero-extended shamt; 0: operand A = read_data1.
- alu_srcB  in  32  operand B (rt value or extended immediate, muxed upstream).
- branch_en  in  1  branch evaluate strobe.
- imm  in  32  sign-extended branch offset (word units).
- pc  in  32  current PC, word-indexed, already incremented.
- alu_result  out  32  registered result.
- hi  out  32  registered upper product word.
- lo  out  32  registered lower product word.
- overflow  out  1  registered signed overflow.
- alu_zero  out  1  registered flag; 1 iff the new alu_result is 0.
- pc_out  out  32  registered next PC after branch evaluation.

Behaviour:
- Reset (synchronous, reset=1 at the edge): all outputs become 0. Reset has priority over en and branch_en.
- Operand A is combinational: A = select_shamt ? {27'b0, shamt} : read_data1.
- On an edge with en=1, registers load from the combinational results. Latency is 1 cycle.
- With en=0, alu_result, overflow, alu_zero, hi and lo hold their values.
- alu_control encoding, with A as operand A and B as alu_srcB:
  - 0 ADD: A+B; overflow = signed overflow.
  - 1 SUB: A−B; overflow = signed overflow.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOR.
  - 6 SLT: signed A<B gives 1, else 0.
  - 7 SLTU: unsigned compare.
  - 8 SLL: B << A[4:0].
  - 9 SRL: logical B >> A[4:0].
  - 10 SRA: arithmetic shift.
  - 11 MULT: signed 64-bit {hi,lo} = A*B; alu_result = lo.
  - 12 MULTU: unsigned 64-bit {hi,lo} = A*B; alu_result = lo.
  - 13 ADDU: no overflow.
  - 14 SUBU: no overflow.
  - 15 LUI: B << 16.
- overflow is written 0 for every opcode except ADD and SUB.
- hi and lo change only on opcodes 11 and 12; every other opcode leaves them unchanged.
- Only A[4:0] is used as the shift amount; shifts by 0 pass B through unchanged.
- Wrap-around: all results are truncated to 32 bits. Overflow does not trap or suppress the write.
- Branch evaluation, on an edge with branch_en=1:
  - pc_out = alu_zero ? pc + imm : pc, where alu_zero is the registered value held before this edge.
  - The addition is modulo 2^32; negative imm moves backward.
  - With branch_en=0, pc_out holds.
- Simultaneous en and branch_en: the branch uses the old alu_zero, and the ALU registers update independently.

Optional Feature:
- Macro: ALU_MULT_EN.
- Defined: opcodes 11 and 12 perform the multiply as specified.
- Undefined:
  - no multiplier is built;
  - opcodes 11 and 12 write alu_result=0, alu_zero=1 and overflow=0;
  - hi and lo stay at 0 from reset forever.

Decomposition:
- Shared package alu_pkg: the 4-bit opcode localparams (ALU_ADD..ALU_LUI) and the WIDTH constant, reused by the decoder.
- One natural sub-module: alu_src_sel, the combinational operand-A mux.
- The branch adder stays inline.

Test Plan:
- reset=1 for 2 cycles with en=1, branch_en=1 -> all outputs 0. After release with en=0 and branch_en=0 -> outputs stay 0.
- ADD, A=0x7FFFFFFF, B=1, en=1 -> next cycle alu_result=0x80000000, overflow=1, alu_zero=0. Then ADDU with the same operands -> overflow=0.
- SLL, select_shamt=1, shamt=4, read_data1=0xFFFF (ignored), B=1 -> alu_result=0x10. SRA with shamt=4, B=0x80000000 -> 0xF8000000.
- SUB 5−5 (alu_zero=1), then branch_en with pc=0x10, imm=0xFFFFFFFE -> pc_out=0x0E. SUB 5−3, then branch -> pc_out=0x10.
- With ALU_MULT_EN: MULT, A=0xFFFFFFFF, B=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=1, lo=0xFFFFFFFE. A following OR leaves hi and lo unchanged.
- After SLT with A=−1, B=1 (result 1), drop en and change the inputs -> alu_result stays 1 for 3 cycles.
